// File: rtl/player_physics.sv
// rtl/player_physics.sv - frame-stepped player movement: clamped walk, one-shot jump, timed smash.
// All state advances only on frame_tick; buttons must be released between actions.
module player_physics #(
  parameter int X_MIN        = 0,
  parameter int X_MAX        = 600,
  parameter int START_X      = 300,
  parameter int GROUND_Y     = 400,
  parameter int MOVE_SPEED   = 4,
  parameter int JUMP_VEL     = 12,
  parameter int GRAVITY      = 1,
  parameter int MAX_FALL     = 12,
  parameter int SMASH_FRAMES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       op_move_left,
  input  logic       op_move_right,
  input  logic       op_jump,
  input  logic       op_smash,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [7:0] vel_y,
  output logic [1:0] state,
  output logic       smash_active,
  output logic       jump_pulse
);

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_AIR    = 2'd1,
    ST_SMASH  = 2'd2
  } state_t;

  localparam logic signed [10:0] XMIN_S   = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S   = 11'(X_MAX);
  localparam logic signed [10:0] MOVE_S   = 11'(MOVE_SPEED);
  localparam logic signed [10:0] GROUND_S = 11'(GROUND_Y);
  localparam logic [9:0]         XMIN_U   = 10'(X_MIN);
  localparam logic [9:0]         XMAX_U   = 10'(X_MAX);
  localparam logic [9:0]         START_U  = 10'(START_X);
  localparam logic [9:0]         GROUND_U = 10'(GROUND_Y);
  localparam logic signed [7:0]  JUMP_V   = 8'(-JUMP_VEL);
  localparam logic signed [8:0]  GRAV_S   = 9'(GRAVITY);
  localparam logic signed [8:0]  MAXF_S   = 9'(MAX_FALL);
  localparam logic signed [7:0]  MAXF_V   = 8'(MAX_FALL);
  localparam logic [7:0]         SMASH_LD = 8'(SMASH_FRAMES - 1);

  logic [9:0]        pos_x_q, pos_x_d;
  logic [9:0]        pos_y_q, pos_y_d;
  logic signed [7:0] vel_q, vel_d;
  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              jump_armed_q, jump_armed_d;
  logic              smash_armed_q, smash_armed_d;
  logic              jump_pulse_q, jump_pulse_d;

  logic signed [10:0] x_cand;
  logic [9:0]         x_next;
  logic signed [10:0] y_next;
  logic signed [8:0]  vel_inc;
  logic signed [7:0]  vel_fall;
  logic               landed;
  logic               airborne;
  logic               vert_step;

  // Horizontal candidate in 11-bit signed so a step below X_MIN cannot wrap.
  always_comb begin
    x_cand = $signed({1'b0, pos_x_q});
    if (op_move_left && !op_move_right) begin
      x_cand = x_cand - MOVE_S;
    end else if (op_move_right && !op_move_left) begin
      x_cand = x_cand + MOVE_S;
    end
    if (x_cand < XMIN_S) begin
      x_next = XMIN_U;
    end else if (x_cand > XMAX_S) begin
      x_next = XMAX_U;
    end else begin
      x_next = x_cand[9:0];
    end
  end

  always_comb begin
    y_next   = $signed({1'b0, pos_y_q}) + $signed({{3{vel_q[7]}}, vel_q});
    vel_inc  = $signed({vel_q[7], vel_q}) + GRAV_S;
    vel_fall = (vel_inc > MAXF_S) ? MAXF_V : vel_inc[7:0];
    landed   = (y_next >= GROUND_S);
    airborne = (pos_y_q != GROUND_U) || (vel_q != 8'sd0);
  end

  always_comb begin
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    vel_d         = vel_q;
    state_d       = state_q;
    cnt_d         = cnt_q;
    jump_armed_d  = jump_armed_q;
    smash_armed_d = smash_armed_q;
    jump_pulse_d  = 1'b0;
    vert_step     = 1'b0;

    if (frame_tick) begin
      if (!op_jump) begin
        jump_armed_d = 1'b1;
      end
      if (!op_smash) begin
        smash_armed_d = 1'b1;
      end
      if (state_q != ST_SMASH) begin
        pos_x_d = x_next;
      end

      case (state_q)
        ST_GROUND: begin
          if (op_jump && jump_armed_q) begin
            vel_d        = JUMP_V;
            state_d      = ST_AIR;
            jump_pulse_d = 1'b1;
            jump_armed_d = 1'b0;
            // A smash pressed together with the jump is consumed, not deferred.
            if (op_smash) begin
              smash_armed_d = 1'b0;
            end
          end else if (op_smash && smash_armed_q) begin
            state_d       = ST_SMASH;
            cnt_d         = SMASH_LD;
            smash_armed_d = 1'b0;
          end
        end
        ST_AIR: begin
          vert_step = 1'b1;
          if (op_smash && smash_armed_q) begin
            state_d       = ST_SMASH;
            cnt_d         = SMASH_LD;
            smash_armed_d = 1'b0;
          end else if (landed) begin
            state_d = ST_GROUND;
          end
        end
        ST_SMASH: begin
          vert_step = airborne;
          if (cnt_q == 8'd0) begin
            state_d = (!airborne || landed) ? ST_GROUND : ST_AIR;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: begin
          state_d = ST_GROUND;
        end
      endcase

      if (vert_step) begin
        if (landed) begin
          pos_y_d = GROUND_U;
          vel_d   = 8'sd0;
        end else if (y_next < 11'sd0) begin
          pos_y_d = 10'd0;
          vel_d   = 8'sd0;
        end else begin
          pos_y_d = y_next[9:0];
          vel_d   = vel_fall;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_x_q       <= START_U;
      pos_y_q       <= GROUND_U;
      vel_q         <= 8'sd0;
      state_q       <= ST_GROUND;
      cnt_q         <= 8'd0;
      jump_armed_q  <= 1'b1;
      smash_armed_q <= 1'b1;
      jump_pulse_q  <= 1'b0;
    end else begin
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      vel_q         <= vel_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      jump_armed_q  <= jump_armed_d;
      smash_armed_q <= smash_armed_d;
      jump_pulse_q  <= jump_pulse_d;
    end
  end

  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign vel_y        = vel_q;
  assign state        = state_q;
  assign smash_active = (state_q == ST_SMASH);
  assign jump_pulse   = jump_pulse_q;

endmodule
